// File: rtl/port_pkg.sv
// port_pkg: constants shared by the port bridge and its FIFOs.
//   PORT_FIFO_DEPTH        default number of entries per FIFO
//   STAT_*                 bit positions inside the CPU status word
//   CTRL_*                 bit positions inside the CPU control word
//   sat_nibble()           clamps an occupancy count to a 4-bit field
package port_pkg;

    localparam int PORT_FIFO_DEPTH = 8;

    localparam int STAT_TX_FULL    = 15;
    localparam int STAT_TX_EMPTY   = 14;
    localparam int STAT_RX_FULL    = 13;
    localparam int STAT_RX_EMPTY   = 12;
    localparam int STAT_TX_OVF     = 11;
    localparam int STAT_RX_UDF     = 10;
    localparam int STAT_TX_CNT_LSB = 4;
    localparam int STAT_RX_CNT_LSB = 0;

    localparam int CTRL_CLR   = 0;
    localparam int CTRL_FLUSH = 1;

    // A 16-deep FIFO reaches 16, which does not fit the nibble; the full bit
    // carries that case instead.
    function automatic logic [3:0] sat_nibble(input logic [4:0] cnt);
        if (cnt > 5'd15) begin
            sat_nibble = 4'd15;
        end else begin
            sat_nibble = cnt[3:0];
        end
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with pointer/count bookkeeping.
//   push/pop  request strobes, gated internally by full/empty and flush
//   flush     empties the FIFO on this edge, overriding push and pop
//   din/dout  write data / head of queue (0 while empty)
//   count     occupancy 0..DEPTH; full/empty derived from it
module sync_fifo
    import port_pkg::*;
#(
    parameter int DEPTH  = PORT_FIFO_DEPTH,
    parameter int DATA_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      flush,
    input  logic [DATA_W-1:0]         din,
    output logic [DATA_W-1:0]         dout,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_nx;
    logic              w_do_push;
    logic              w_do_pop;

    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == {CNT_W{1'b0}});
    assign count = r_count;
    // Storage is not reset, so the head is masked while empty.
    assign dout  = empty ? {DATA_W{1'b0}} : r_mem[r_rd_ptr];

    // At full a push is still taken when the head leaves on the same edge;
    // the write lands in the slot the pop is vacating.
    assign w_do_pop  = pop  & ~flush & ~empty;
    assign w_do_push = push & ~flush & (~full | w_do_pop);

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        w_count_nx = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_nx = r_count + CNT_W'(1);
            2'b01:   w_count_nx = r_count - CNT_W'(1);
            default: w_count_nx = r_count;
        endcase
    end

    // Pointer and occupancy registers; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else if (flush) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nx;
        end
    end

    // Data storage write port.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/port_bridge.sv
// port_bridge: CPU register port bridged to an outbound (TX) and an inbound
// (RX) valid/ready stream through two FIFOs.
//   cpu_write/cpu_wdata/cpu_wctrl  push TX word; ctrl bit0 clears sticky
//                                  flags, bit1 flushes both FIFOs
//   cpu_read/cpu_rdata             pop RX head / RX head (0 when empty)
//   cpu_status                     flags and occupancy packed from state
//   tx_valid/tx_ready/tx_data      outbound stream from the TX FIFO head
//   rx_valid/rx_ready/rx_data      inbound stream into the RX FIFO
module port_bridge
    import port_pkg::*;
#(
    parameter int DEPTH  = PORT_FIFO_DEPTH,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_write,
    input  logic              cpu_read,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [DATA_W-1:0] cpu_wctrl,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [DATA_W-1:0] cpu_status,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [DATA_W-1:0] tx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [DATA_W-1:0] rx_data
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              w_flush;
    logic              w_clr;
    logic              w_tx_push;
    logic              w_rx_push;
    logic              w_tx_full;
    logic              w_tx_empty;
    logic              w_rx_full;
    logic              w_rx_empty;
    logic [CNT_W-1:0]  w_tx_count;
    logic [CNT_W-1:0]  w_rx_count;
    logic              w_tx_ovf_evt;
    logic              w_rx_udf_evt;
    logic              r_tx_ovf;
    logic              r_rx_udf;
    logic [15:0]       w_status;
    logic              w_unused_ctrl;

    assign w_flush   = cpu_write & cpu_wctrl[CTRL_FLUSH];
    assign w_clr     = cpu_write & cpu_wctrl[CTRL_CLR];
    assign w_tx_push = cpu_write & ~w_flush;
    assign w_rx_push = rx_valid & ~w_rx_full;
    assign w_unused_ctrl = &{1'b0, cpu_wctrl[DATA_W-1:2]};

    // A write at full is lost unless the head drains on the same edge.
    assign w_tx_ovf_evt = w_tx_push & w_tx_full & ~(~w_tx_empty & tx_ready);
    assign w_rx_udf_evt = cpu_read & w_rx_empty & ~w_flush;

    sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_tx_push),
        .pop   (tx_ready),
        .flush (w_flush),
        .din   (cpu_wdata),
        .dout  (tx_data),
        .count (w_tx_count),
        .full  (w_tx_full),
        .empty (w_tx_empty)
    );

    sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_rx_push),
        .pop   (cpu_read),
        .flush (w_flush),
        .din   (rx_data),
        .dout  (cpu_rdata),
        .count (w_rx_count),
        .full  (w_rx_full),
        .empty (w_rx_empty)
    );

    assign tx_valid = ~w_tx_empty;
    assign rx_ready = ~w_rx_full;

    // Sticky error flags; a same-edge event beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_ovf <= 1'b0;
            r_rx_udf <= 1'b0;
        end else begin
            if (w_tx_ovf_evt) begin
                r_tx_ovf <= 1'b1;
            end else if (w_clr) begin
                r_tx_ovf <= 1'b0;
            end
            if (w_rx_udf_evt) begin
                r_rx_udf <= 1'b1;
            end else if (w_clr) begin
                r_rx_udf <= 1'b0;
            end
        end
    end

    // Status word packing from registered FIFO state and flags.
    always_comb begin
        w_status                              = 16'h0000;
        w_status[STAT_TX_FULL]                = w_tx_full;
        w_status[STAT_TX_EMPTY]               = w_tx_empty;
        w_status[STAT_RX_FULL]                = w_rx_full;
        w_status[STAT_RX_EMPTY]               = w_rx_empty;
        w_status[STAT_TX_OVF]                 = r_tx_ovf;
        w_status[STAT_RX_UDF]                 = r_rx_udf;
        w_status[STAT_TX_CNT_LSB +: 4]        = sat_nibble(5'(w_tx_count));
        w_status[STAT_RX_CNT_LSB +: 4]        = sat_nibble(5'(w_rx_count));
    end

    assign cpu_status = DATA_W'(w_status);

endmodule
